spi_cmd_arbiter: RTL and testbench

SPI_CMD_ARBITER -- requirements
Module: spi_cmd_arbiter

---
 rtl/adar_pkg.sv | 21 ++
 rtl/rr_picker.sv | 36 +++
 rtl/spi_cmd_arbiter.sv | 120 ++++++++++++
 tb/tb_spi_cmd_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adar_pkg.sv
// Shared definitions for the SPI command arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   SPI_*_WIDTH    : default SPI register address/data widths
//   REQ_*          : requester index assignments
package adar_pkg;

  localparam int SPI_ADDR_WIDTH = 14;
  localparam int SPI_DATA_WIDTH = 8;

  localparam int REQ_BEAM = 0;
  localparam int REQ_DET  = 1;
  localparam int REQ_TEMP = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority picker (purely combinational).
//   req        : request vector
//   last_grant : index of the most recent winner; search starts one above it
//   grant      : one-hot winner (zero when no request)
//   grant_idx  : binary index of the winner
module rr_picker #(
  parameter int NUM_REQ   = 3,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  localparam int unsigned NR = NUM_REQ;

  always_comb begin
    logic                 found;
    logic [IDX_WIDTH-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Offsets 1..NR visit every requester once, ending on last_grant itself.
    for (int unsigned i = 1; i <= NR; i++) begin
      idx = IDX_WIDTH'((32'(last_grant) + i) % NR);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Arbitrates register commands from several requesters onto a single SPI
// master, one outstanding command at a time, with a response timeout.
//   req_*          : per-requester command channel (valid/ready handshake)
//   resp_*         : completion pulse to the owning requester, shared data/err
//   spi_cmd_*      : command to the SPI master (valid is a one-cycle pulse)
//   spi_resp_*     : completion from the SPI master
//   busy           : a command is in flight
module spi_cmd_arbiter
  import adar_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_WIDTH     = SPI_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [DATA_WIDTH-1:0]               resp_rdata,
  output logic                                resp_err,
  output logic                                spi_cmd_valid,
  output logic                                spi_cmd_write,
  output logic [ADDR_WIDTH-1:0]               spi_cmd_addr,
  output logic [DATA_WIDTH-1:0]               spi_cmd_wdata,
  input  logic                                spi_resp_valid,
  input  logic [DATA_WIDTH-1:0]               spi_resp_rdata,
  output logic                                busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  arb_state_t         state;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      owner;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win;
  logic [CW-1:0]      tcnt;
  logic               handshake;

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (win),
    .grant_idx  (win_idx)
  );

  // Gated by rst_n so ready reads 0 while reset is held, not just after it.
  assign req_ready = (rst_n && state == IDLE) ? win : '0;
  assign handshake = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_grant    <= IW'(NUM_REQ - 1);
      owner         <= '0;
      tcnt          <= '0;
      spi_cmd_valid <= 1'b0;
      spi_cmd_write <= 1'b0;
      spi_cmd_addr  <= '0;
      spi_cmd_wdata <= '0;
      resp_valid    <= '0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
    end else begin
      spi_cmd_valid <= 1'b0;
      resp_valid    <= '0;
      unique case (state)
        IDLE: begin
          if (handshake) begin
            owner         <= win_idx;
            last_grant    <= win_idx;
            spi_cmd_write <= req_write[win_idx];
            spi_cmd_addr  <= req_addr[win_idx];
            spi_cmd_wdata <= req_wdata[win_idx];
            spi_cmd_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A response in the final timeout cycle still counts as a response.
          if (spi_resp_valid) begin
            resp_rdata        <= spi_resp_rdata;
            resp_err          <= 1'b0;
            resp_valid[owner] <= 1'b1;
            state             <= DONE;
          end else if (tcnt == TO_LAST) begin
            resp_rdata        <= '0;
            resp_err          <= 1'b1;
            resp_valid[owner] <= 1'b1;
            state             <= DONE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed self-checking bench for spi_cmd_arbiter.
//   u_dut    : default timeout, drives the main scenarios
//   u_dut_to : TIMEOUT_CYCLES = 16, for timeout and timeout-boundary cases
module tb_spi_cmd_arbiter;
  import adar_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [2:0]       req_valid, req_ready, req_write, resp_valid;
  logic [2:0][13:0] req_addr;
  logic [2:0][7:0]  req_wdata;
  logic [7:0]       resp_rdata, spi_cmd_wdata, spi_resp_rdata;
  logic             resp_err, spi_cmd_valid, spi_cmd_write, spi_resp_valid, busy;
  logic [13:0]      spi_cmd_addr;

  logic [2:0]       t_req_valid, t_req_ready, t_req_write, t_resp_valid;
  logic [2:0][13:0] t_req_addr;
  logic [2:0][7:0]  t_req_wdata;
  logic [7:0]       t_resp_rdata, t_spi_cmd_wdata, t_spi_resp_rdata;
  logic             t_resp_err, t_spi_cmd_valid, t_spi_cmd_write, t_spi_resp_valid, t_busy;
  logic [13:0]      t_spi_cmd_addr;

  spi_cmd_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(14), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4096)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .spi_cmd_valid(spi_cmd_valid), .spi_cmd_write(spi_cmd_write),
    .spi_cmd_addr(spi_cmd_addr), .spi_cmd_wdata(spi_cmd_wdata),
    .spi_resp_valid(spi_resp_valid), .spi_resp_rdata(spi_resp_rdata),
    .busy(busy)
  );

  spi_cmd_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(14), .DATA_WIDTH(8), .TIMEOUT_CYCLES(16)
  ) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_write(t_req_write),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata),
    .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata), .resp_err(t_resp_err),
    .spi_cmd_valid(t_spi_cmd_valid), .spi_cmd_write(t_spi_cmd_write),
    .spi_cmd_addr(t_spi_cmd_addr), .spi_cmd_wdata(t_spi_cmd_wdata),
    .spi_resp_valid(t_spi_resp_valid), .spi_resp_rdata(t_spi_resp_rdata),
    .busy(t_busy)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Command-pulse monitor on the main DUT: counts commands and flags a second
  // command issued before the previous one saw a response.
  int cmd_count = 0;
  int overlap   = 0;
  bit outstanding = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
    end else if (spi_cmd_valid) begin
      cmd_count <= cmd_count + 1;
      if (outstanding) overlap <= overlap + 1;
      outstanding <= 1'b1;
    end else if (spi_resp_valid) begin
      outstanding <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input bit use_t, input string tag);
    int n = 0;
    while (((use_t ? t_spi_cmd_valid : spi_cmd_valid) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(use_t ? t_spi_cmd_valid : spi_cmd_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;

    rst_n = 1'b0;
    req_valid = 3'b111; req_write = '0; req_addr = '0; req_wdata = '0;
    spi_resp_valid = 1'b0; spi_resp_rdata = '0;
    t_req_valid = '0; t_req_write = '0; t_req_addr = '0; t_req_wdata = '0;
    t_spi_resp_valid = 1'b0; t_spi_resp_rdata = '0;

    // Reset state, with requests already pending
    repeat (2) tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_valid", 32'(spi_cmd_valid), 32'd0);
    chk("rst_cmd_addr", 32'(spi_cmd_addr), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single read from the detector requester
    req_addr[REQ_DET] = 14'h033;
    req_valid = 3'b010;
    #1 chk("rd_ready", 32'(req_ready), 32'b010);
    tick();
    req_valid = '0;
    chk("rd_cmd_valid", 32'(spi_cmd_valid), 32'd1);
    chk("rd_cmd_addr", 32'(spi_cmd_addr), 32'h033);
    chk("rd_cmd_write", 32'(spi_cmd_write), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_ready_issue", 32'(req_ready), 32'd0);
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'hEE;   // lands in ISSUE: must be ignored
    tick();
    spi_resp_valid = 1'b0;
    chk("rd_cmd_one_pulse", 32'(spi_cmd_valid), 32'd0);
    chk("rd_issue_resp_ignored", 32'(resp_valid), 32'd0);
    repeat (18) tick();
    chk("rd_wait_quiet", 32'(resp_valid), 32'd0);
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'h5A;
    tick();
    spi_resp_valid = 1'b0;
    chk("rd_resp_valid", 32'(resp_valid), 32'b010);
    chk("rd_resp_rdata", 32'(resp_rdata), 32'h5A);
    chk("rd_resp_err", 32'(resp_err), 32'd0);
    chk("rd_ready_done", 32'(req_ready), 32'd0);
    tick();
    chk("rd_resp_pulse", 32'(resp_valid), 32'd0);
    chk("rd_idle", 32'(busy), 32'd0);
    chk("rd_cmd_count", 32'(cmd_count), 32'd1);

    // Spurious response while idle
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'h77;
    tick();
    spi_resp_valid = 1'b0;
    chk("spur_resp", 32'(resp_valid), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    tick();
    chk("spur_resp_late", 32'(resp_valid), 32'd0);
    chk("spur_no_cmd", 32'(spi_cmd_valid), 32'd0);

    // Contention from a fresh reset: grant order 0,1,2,0,1,2
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) req_addr[i] = 14'(14'h100 + i);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      e = k % 3;
      wait_cmd(1'b0, "rr_cmd_seen");
      chk("rr_grant_addr", 32'(spi_cmd_addr), 32'h100 + e);
      tick();
      tick();
      spi_resp_valid = 1'b1; spi_resp_rdata = 8'(8'h30 + k);
      tick();
      spi_resp_valid = 1'b0;
      chk("rr_resp_owner", 32'(resp_valid), 32'd1 << e);
      chk("rr_resp_rdata", 32'(resp_rdata), 32'h30 + k);
    end
    req_valid = '0;
    chk("rr_no_overlap", 32'(overlap), 32'd0);

    // Reset in the middle of WAIT, then requester 0 must win over 2
    req_addr[REQ_BEAM] = 14'h0AA;
    req_addr[REQ_TEMP] = 14'h2BB;
    req_valid = 3'b101;
    wait_cmd(1'b0, "rw_cmd_seen");
    chk("rw_first_addr", 32'(spi_cmd_addr), 32'h0AA);
    tick();
    tick();
    chk("rw_in_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_async_busy", 32'(busy), 32'd0);
    chk("rw_async_addr", 32'(spi_cmd_addr), 32'd0);
    chk("rw_async_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("rw_no_resp", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rw_prio_ready", 32'(req_ready), 32'b001);
    wait_cmd(1'b0, "rw_cmd0_seen");
    chk("rw_cmd0_addr", 32'(spi_cmd_addr), 32'h0AA);
    tick();
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'h01;
    tick();
    spi_resp_valid = 1'b0;
    chk("rw_resp0", 32'(resp_valid), 32'b001);
    req_valid = 3'b100;
    tick();
    chk("rw_ready2", 32'(req_ready), 32'b100);
    wait_cmd(1'b0, "rw_cmd2_seen");
    chk("rw_cmd2_addr", 32'(spi_cmd_addr), 32'h2BB);
    tick();
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'h02;
    tick();
    spi_resp_valid = 1'b0;
    chk("rw_resp2", 32'(resp_valid), 32'b100);
    req_valid = '0;
    tick();

    // Back-to-back writes from requester 0
    req_write[REQ_BEAM] = 1'b1;
    req_addr[REQ_BEAM]  = 14'h1000;
    req_wdata[REQ_BEAM] = 8'h11;
    req_valid = 3'b001;
    wait_cmd(1'b0, "bw_cmd1_seen");
    chk("bw_cmd1_write", 32'(spi_cmd_write), 32'd1);
    chk("bw_cmd1_addr", 32'(spi_cmd_addr), 32'h1000);
    chk("bw_cmd1_wdata", 32'(spi_cmd_wdata), 32'h11);
    req_addr[REQ_BEAM]  = 14'h1001;
    req_wdata[REQ_BEAM] = 8'h22;
    tick();
    tick();
    chk("bw_cmd1_stable", 32'(spi_cmd_addr), 32'h1000);
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'h99;
    tick();
    spi_resp_valid = 1'b0;
    chk("bw_resp1", 32'(resp_valid), 32'b001);
    chk("bw_resp1_rdata", 32'(resp_rdata), 32'h99);
    chk("bw_resp1_err", 32'(resp_err), 32'd0);
    wait_cmd(1'b0, "bw_cmd2_seen");
    chk("bw_cmd2_addr", 32'(spi_cmd_addr), 32'h1001);
    chk("bw_cmd2_wdata", 32'(spi_cmd_wdata), 32'h22);
    req_valid = '0;
    tick();
    spi_resp_valid = 1'b1; spi_resp_rdata = 8'h42;
    tick();
    spi_resp_valid = 1'b0;
    chk("bw_resp2", 32'(resp_valid), 32'b001);
    chk("bw_resp2_rdata", 32'(resp_rdata), 32'h42);
    tick();
    chk("cmd_total", 32'(cmd_count), 32'd12);
    chk("final_no_overlap", 32'(overlap), 32'd0);

    // Timeout with a silent SPI master (TIMEOUT_CYCLES = 16)
    t_spi_resp_rdata = 8'hAB;
    t_req_addr[REQ_BEAM] = 14'h055;
    t_req_valid = 3'b001;
    wait_cmd(1'b1, "to_cmd_seen");
    t_req_valid = '0;
    n = 0;
    while (t_resp_valid === 3'b000 && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'd17);
    chk("to_owner", 32'(t_resp_valid), 32'b001);
    chk("to_err", 32'(t_resp_err), 32'd1);
    chk("to_rdata", 32'(t_resp_rdata), 32'h00);
    tick();
    chk("to_idle", 32'(t_busy), 32'd0);

    // Next request is served; its response coincides with the last timeout cycle
    t_req_addr[REQ_DET] = 14'h066;
    t_req_valid = 3'b010;
    wait_cmd(1'b1, "to2_cmd_seen");
    t_req_valid = '0;
    chk("to2_cmd_addr", 32'(t_spi_cmd_addr), 32'h066);
    repeat (16) tick();
    chk("to2_not_yet", 32'(t_resp_valid), 32'd0);
    t_spi_resp_valid = 1'b1; t_spi_resp_rdata = 8'h3C;
    tick();
    t_spi_resp_valid = 1'b0;
    chk("to2_resp", 32'(t_resp_valid), 32'b010);
    chk("to2_err", 32'(t_resp_err), 32'd0);
    chk("to2_rdata", 32'(t_resp_rdata), 32'h3C);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
